// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges a 256-bit cache-line request (read or write) to a
// 64-bit, 4-beat burst memory interface, and acknowledges with one resp_o pulse.
//
// Handshake: read_i/write_i are level requests. They are sampled only in IDLE
// and must be held until resp_o. The memory accepts or returns one beat on each
// cycle that has resp_i=1. read_o/write_o stay high from the first beat to the
// last beat, and they drop on the edge that carries the fourth resp_i.
module cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    localparam int OFF_W = $clog2(LINE_W / 8);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        RD_DONE  = 3'd2,
        WR_BURST = 3'd3,
        WR_DONE  = 3'd4
    } state_t;

    state_t              state;
    logic [1:0]          cnt;
    logic [1:0]          next_cnt;
    logic [LINE_W-1:0]   wbuf;
    logic [LINE_W-1:0]   rbuf;

    assign next_cnt = cnt + 2'd1;

    // Burst sequencer: every output is driven from this one registered FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            wbuf      <= '0;
            rbuf      <= '0;
            line_o    <= '0;
            burst_o   <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_o <= 1'b0;
                    cnt    <= 2'd0;
                    // A read request takes priority when both requests are high.
                    if (read_i) begin
                        address_o <= {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        read_o    <= 1'b1;
                        state     <= RD_BURST;
                    end else if (write_i) begin
                        address_o <= {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        wbuf      <= line_i;
                        burst_o   <= line_i[BURST_W-1:0];
                        write_o   <= 1'b1;
                        state     <= WR_BURST;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        rbuf[cnt*BURST_W +: BURST_W] <= burst_i;
                        cnt <= next_cnt;
                        if (cnt == 2'd3) begin
                            // Assemble the completed line from the final beat.
                            line_o <= {burst_i, rbuf[LINE_W-BURST_W-1:0]};
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= RD_DONE;
                        end
                    end
                end
                RD_DONE: begin
                    resp_o <= 1'b0;
                    state  <= IDLE;
                end
                WR_BURST: begin
                    if (resp_i) begin
                        cnt <= next_cnt;
                        // Present the next beat on the same edge that retires this one.
                        burst_o <= wbuf[next_cnt*BURST_W +: BURST_W];
                        if (cnt == 2'd3) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state   <= WR_DONE;
                        end
                    end
                end
                WR_DONE: begin
                    resp_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= 2'd0;
                    read_o  <= 1'b0;
                    write_o <= 1'b0;
                    resp_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed testbench for cacheline_adaptor. Inputs are driven at the negedge,
// and outputs are sampled at the negedge, which keeps both away from the active edge.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst_n;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks = 0;
    int errors = 0;

    logic [63:0]  beats [4];
    logic [255:0] exp_line;

    cacheline_adaptor dut (
        .clk(clk), .rst_n(rst_n),
        .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        line_i = '0; address_i = '0; read_i = 0; write_i = 0; burst_i = '0; resp_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'h0 || burst_o !== 64'h0 || line_o !== '0) begin
            errors++;
            $display("FAIL reset_state: rd=%b wr=%b resp=%b addr=%h burst=%h line=%h (want all 0)",
                     read_o, write_o, resp_o, address_o, burst_o, line_o);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    // Both requests are high: only a read burst may run, and the write line is never driven.
    task automatic test_conflict();
        address_i = 32'h0000_0040;
        read_i = 1; write_i = 1;
        line_i = {4{64'hDEAD_BEEF_0BAD_F00D}};
        beats[0] = 64'h0101_0101_0101_0101; beats[1] = 64'h0202_0202_0202_0202;
        beats[2] = 64'h0303_0303_0303_0303; beats[3] = 64'h0404_0404_0404_0404;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (read_o !== 1'b1 || write_o !== 1'b0 || burst_o !== 64'h0) begin
                errors++;
                $display("FAIL conflict_beat%0d: rd=%b wr=%b burst=%h (want rd=1 wr=0 burst=0)",
                         i, read_o, write_o, burst_o);
            end
            burst_i = beats[i]; resp_i = 1;
            @(negedge clk);
        end
        resp_i = 0; read_i = 0; write_i = 0;
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        checks++;
        if (resp_o !== 1'b1 || write_o !== 1'b0 || line_o !== exp_line) begin
            errors++;
            $display("FAIL conflict_done: resp=%b wr=%b line=%h (want resp=1 wr=0 line=%h)",
                     resp_o, write_o, line_o, exp_line);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (write_o !== 1'b0 || read_o !== 1'b0) begin
            errors++;
            $display("FAIL conflict_after: rd=%b wr=%b (want 0 0)", read_o, write_o);
        end
    endtask

    task automatic test_read();
        int cyc;
        address_i = 32'h0000_1234; read_i = 1;
        beats[0] = {8{8'h11}}; beats[1] = {8{8'h22}}; beats[2] = {8{8'h33}}; beats[3] = {8{8'h44}};
        @(negedge clk);
        cyc = 1;
        checks++;
        if (read_o !== 1'b1 || address_o !== 32'h0000_1220) begin
            errors++;
            $display("FAIL read_start: rd=%b addr=%h (want rd=1 addr=00001220)", read_o, address_o);
        end
        for (int i = 0; i < 4; i++) begin
            burst_i = beats[i]; resp_i = 1;
            if (i == 1) address_i = 32'hFFFF_FFFF;
            @(negedge clk);
            cyc++;
            if (i < 3) begin
                checks++;
                if (read_o !== 1'b1 || resp_o !== 1'b0 || address_o !== 32'h0000_1220) begin
                    errors++;
                    $display("FAIL read_beat%0d: rd=%b resp=%b addr=%h (want 1 0 00001220)",
                             i, read_o, resp_o, address_o);
                end
            end
        end
        resp_i = 0; read_i = 0;
        exp_line = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        checks++;
        if (resp_o !== 1'b1 || read_o !== 1'b0 || line_o !== exp_line || cyc != 5) begin
            errors++;
            $display("FAIL read_done: resp=%b rd=%b cyc=%0d line=%h (want 1 0 5 %h)",
                     resp_o, read_o, cyc, line_o, exp_line);
        end
        @(negedge clk);
        checks++;
        if (resp_o !== 1'b0) begin
            errors++;
            $display("FAIL read_resp_single: resp=%b (want 0)", resp_o);
        end
    endtask

    task automatic test_write();
        logic [63:0] w [4];
        w[0] = 64'hAAAA_0000_AAAA_0000; w[1] = 64'hBBBB_1111_BBBB_1111;
        w[2] = 64'hCCCC_2222_CCCC_2222; w[3] = 64'hDDDD_3333_DDDD_3333;
        address_i = 32'h8000_007F; line_i = {w[3], w[2], w[1], w[0]}; write_i = 1;
        @(negedge clk);
        checks++;
        if (address_o !== 32'h8000_0060) begin
            errors++;
            $display("FAIL write_addr: addr=%h (want 80000060)", address_o);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (write_o !== 1'b1 || burst_o !== w[i] || resp_o !== 1'b0) begin
                errors++;
                $display("FAIL write_beat%0d: wr=%b burst=%h resp=%b (want 1 %h 0)",
                         i, write_o, burst_o, resp_o, w[i]);
            end
            resp_i = 1;
            if (i == 0) line_i = '0;
            @(negedge clk);
        end
        resp_i = 0; write_i = 0;
        checks++;
        if (write_o !== 1'b0 || resp_o !== 1'b1 || line_o !== exp_line) begin
            errors++;
            $display("FAIL write_done: wr=%b resp=%b line=%h (want 0 1 %h)", write_o, resp_o, line_o, exp_line);
        end
        @(negedge clk);
        checks++;
        if (resp_o !== 1'b0) begin
            errors++;
            $display("FAIL write_resp_single: resp=%b (want 0)", resp_o);
        end
    endtask

    task automatic test_read_gaps();
        logic pat [7];
        int b;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        beats[0] = 64'h0123_4567_89AB_CDEF; beats[1] = 64'hFEDC_BA98_7654_3210;
        beats[2] = 64'h5555_AAAA_5555_AAAA; beats[3] = 64'h0F0F_F0F0_0F0F_F0F0;
        address_i = 32'h0000_2000; read_i = 1;
        @(negedge clk);
        b = 0;
        for (int i = 0; i < 7; i++) begin
            resp_i = pat[i];
            burst_i = pat[i] ? beats[b] : 64'hBAD0_BAD0_BAD0_BAD0;
            if (pat[i]) b++;
            @(negedge clk);
            if (i < 6) begin
                checks++;
                if (read_o !== 1'b1 || resp_o !== 1'b0) begin
                    errors++;
                    $display("FAIL gaps_cycle%0d: rd=%b resp=%b (want 1 0)", i, read_o, resp_o);
                end
            end
        end
        resp_i = 0; read_i = 0;
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        checks++;
        if (resp_o !== 1'b1 || read_o !== 1'b0 || line_o !== exp_line) begin
            errors++;
            $display("FAIL gaps_done: resp=%b rd=%b line=%h (want 1 0 %h)", resp_o, read_o, line_o, exp_line);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        address_i = 32'h0000_3000; read_i = 1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            burst_i = {8{8'hE0 + 8'(i)}}; resp_i = 1;
            @(negedge clk);
        end
        resp_i = 0;
        #2 rst_n = 0;
        #1;
        checks++;
        if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'h0 || burst_o !== 64'h0 || line_o !== '0) begin
            errors++;
            $display("FAIL async_reset: rd=%b wr=%b resp=%b addr=%h burst=%h line=%h (want all 0)",
                     read_o, write_o, resp_o, address_o, burst_o, line_o);
        end
        read_i = 0;
        @(negedge clk);
        checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: resp=%b rd=%b (want 0 0)", resp_o, read_o);
        end
        rst_n = 1;
        @(negedge clk);
        beats[0] = 64'h1000_0000_0000_0001; beats[1] = 64'h2000_0000_0000_0002;
        beats[2] = 64'h3000_0000_0000_0003; beats[3] = 64'h4000_0000_0000_0004;
        address_i = 32'h0000_3010; read_i = 1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            burst_i = beats[i]; resp_i = 1;
            @(negedge clk);
        end
        resp_i = 0; read_i = 0;
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        checks++;
        if (resp_o !== 1'b1 || line_o !== exp_line || address_o !== 32'h0000_3000) begin
            errors++;
            $display("FAIL reset_fresh_read: resp=%b addr=%h line=%h (want 1 00003000 %h)",
                     resp_o, address_o, line_o, exp_line);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [255:0] old_line;
        int wait_cyc;
        old_line = exp_line;
        address_i = 32'h0000_4000; line_i = {4{64'h7777_8888_9999_6666}}; write_i = 1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            resp_i = 1;
            @(negedge clk);
        end
        resp_i = 0;
        checks++;
        if (resp_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_write_resp: resp=%b (want 1)", resp_o);
        end
        write_i = 0; read_i = 1; address_i = 32'h0000_5000;
        wait_cyc = 0;
        while (read_o !== 1'b1 && wait_cyc < 4) begin
            @(negedge clk);
            wait_cyc++;
        end
        checks++;
        if (read_o !== 1'b1 || line_o !== old_line) begin
            errors++;
            $display("FAIL b2b_read_start: rd=%b after %0d cycles line=%h (want rd=1 line=%h)",
                     read_o, wait_cyc, line_o, old_line);
        end
        beats[0] = 64'hA1A1_A1A1_A1A1_A1A1; beats[1] = 64'hB2B2_B2B2_B2B2_B2B2;
        beats[2] = 64'hC3C3_C3C3_C3C3_C3C3; beats[3] = 64'hD4D4_D4D4_D4D4_D4D4;
        for (int i = 0; i < 4; i++) begin
            burst_i = beats[i]; resp_i = 1;
            @(negedge clk);
            if (i < 3) begin
                checks++;
                if (line_o !== old_line) begin
                    errors++;
                    $display("FAIL b2b_line_hold%0d: line=%h (want %h)", i, line_o, old_line);
                end
            end
        end
        resp_i = 0; read_i = 0;
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        checks++;
        if (resp_o !== 1'b1 || line_o !== exp_line) begin
            errors++;
            $display("FAIL b2b_read_done: resp=%b line=%h (want 1 %h)", resp_o, line_o, exp_line);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_read();
        test_write();
        test_read_gaps();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
